// File: rtl/dk_motion_ctrl.sv
// rtl/dk_motion_ctrl.sv - Frame-tick driven character motion FSM (idle/walk/jump/fall).
// Position commits and state changes happen only on the tick edge; key edges are latched between ticks.
module dk_motion_ctrl #(
    parameter int          TICK_PERIOD = 5000000,
    parameter int          TICK_POINT  = 4500000,
    parameter int          JUMP_FRAMES = 10,
    parameter logic [7:0]  JUMP_KEY    = 8'h29,
    parameter logic [7:0]  RIGHT_KEY   = 8'h74,
    parameter logic [7:0]  LEFT_KEY    = 8'h6B,
    parameter logic [15:0] SPAWN_X     = 16'd0,
    parameter logic [15:0] SPAWN_Y     = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  keycode,
    input  logic        press,
    input  logic        grounded,
    input  logic [15:0] next_x,
    input  logic [15:0] next_y,
    output logic [24:0] counter,
    output logic [15:0] prev_x,
    output logic [15:0] prev_y,
    output logic [3:0]  dk_motion,
    output logic [18:0] jump_num,
    output logic        facing,
    output logic        tick
);

    localparam logic [24:0] CNT_LAST = 25'(TICK_PERIOD - 1);
    localparam logic [24:0] CNT_TICK = 25'(TICK_POINT);
    localparam logic [18:0] JF       = 19'(JUMP_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_JUMP, S_FALL} state_t;

    state_t      state_q, state_d;
    logic [24:0] counter_q, counter_d;
    logic [15:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic [3:0]  motion_q, motion_d;
    logic [18:0] jump_num_q, jump_num_d;
    logic        facing_q, facing_d;
    logic        jump_req_q, jump_req_d;
    logic        armed_q, armed_d;
    logic        key_r, key_l, key_j, tick_w, enter_jump;

    always_comb begin
        key_r      = (keycode == RIGHT_KEY) && press;
        key_l      = !key_r && (keycode == LEFT_KEY) && press;
        key_j      = (keycode == JUMP_KEY) && press;
        tick_w     = !reset && run && (counter_q == CNT_TICK);

        state_d    = state_q;
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
        jump_num_d = jump_num_q;
        facing_d   = facing_q;
        jump_req_d = jump_req_q;
        armed_d    = armed_q;
        enter_jump = 1'b0;
        motion_d   = 4'd1;

        if (!run)                      counter_d = '0;
        else if (counter_q == CNT_LAST) counter_d = '0;
        else                           counter_d = counter_q + 25'd1;

        if (!key_j)            armed_d    = 1'b1;
        if (key_j && armed_q)  jump_req_d = 1'b1;

        if (tick_w) begin
            prev_x_d   = next_x;
            prev_y_d   = next_y;
            jump_req_d = 1'b0;
            if (key_r)      facing_d = 1'b0;
            else if (key_l) facing_d = 1'b1;

            case (state_q)
                S_IDLE, S_WALK: begin
                    if (jump_req_q && grounded) begin
                        state_d    = S_JUMP;
                        jump_num_d = '0;
                        enter_jump = 1'b1;
                    end else if (!grounded) begin
                        state_d = S_FALL;
                    end else if (key_r || key_l) begin
                        state_d = S_WALK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_JUMP: begin
                    if (jump_num_q < JF)            jump_num_d = jump_num_q + 19'd1;
                    if (jump_num_q + 19'd1 >= JF)   state_d    = S_FALL;
                end
                default: begin
                    if (grounded) state_d = (key_r || key_l) ? S_WALK : S_IDLE;
                end
            endcase
        end

        // A held jump key must be released before it can arm another jump.
        if (enter_jump) armed_d = 1'b0;

        case (state_d)
            S_IDLE:  motion_d = 4'd1 + {3'd0, facing_d};
            S_JUMP:  motion_d = 4'd4 + {3'd0, facing_d};
            S_WALK:  motion_d = 4'd6 + {3'd0, facing_d};
            default: motion_d = 4'd8 + {3'd0, facing_d};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            prev_x_q   <= SPAWN_X;
            prev_y_q   <= SPAWN_Y;
            motion_q   <= 4'd1;
            jump_num_q <= '0;
            facing_q   <= 1'b0;
            jump_req_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
            motion_q   <= motion_d;
            jump_num_q <= jump_num_d;
            facing_q   <= facing_d;
            jump_req_q <= jump_req_d;
            armed_q    <= armed_d;
        end
    end

    assign counter   = counter_q;
    assign prev_x    = prev_x_q;
    assign prev_y    = prev_y_q;
    assign dk_motion = motion_q;
    assign jump_num  = jump_num_q;
    assign facing    = facing_q;
    assign tick      = tick_w;

endmodule
